// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states, vector helper.
package intc_pkg;

    localparam logic [1:0] INTC_PENDING = 2'd0;
    localparam logic [1:0] INTC_MASK    = 2'd1;
    localparam logic [1:0] INTC_CAUSE   = 2'd2;
    localparam logic [1:0] INTC_LEVEL   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

    function automatic logic [31:0] intc_vector(input logic [2:0]  id,
                                                input logic [31:0] base,
                                                input logic [31:0] stride);
        return base + 32'(id) * stride;
    endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// Two-flop synchroniser per line plus a registered rising-edge pulse.
// The synchronised level is exported for level-triggered sources.
module intc_sync_edge #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] irq,
    output logic [W-1:0] rise,
    output logic [W-1:0] level
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] sync3;
    logic [W-1:0] rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            rise_q <= '0;
        end else begin
            sync1  <= irq;
            sync2  <= sync1;
            sync3  <= sync2;
            rise_q <= sync2 & ~sync3;
        end
    end

    assign rise  = rise_q;
    assign level = sync2;

endmodule

// File: rtl/int_controller.sv
// Prioritised interrupt controller; INTC_LEVEL_TRIG_EN adds a per-source LEVEL register at address 3.
//   state   | meaning
//   IDLE    | nothing requested, waiting for an eligible pending bit
//   REQ     | int_sig high, int_vector tracks the current winner
//   SERVICE | one interrupt in service, no nesting until rfe
module int_controller
    import intc_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq,
    output logic               int_sig,
    output logic [31:0]        int_vector,
    input  logic               int_ack,
    input  logic               rfe,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    output logic [7:0]         cfg_rdata
);

    intc_state_t        state, state_nxt;
    logic [NUM_SRC-1:0] rise, sync_lvl, level_en;
    logic [NUM_SRC-1:0] pending, pending_nxt, mask, mask_nxt;
    logic [NUM_SRC-1:0] eligible, eligible_nxt, w1c, ack_clr;
    logic [2:0]         win, win_nxt, svc_id;
    logic               svc_valid, ack_take, rfe_take;

    function automatic logic [2:0] lowest(input logic [NUM_SRC-1:0] v);
        lowest = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest = 3'(i);
        end
    endfunction

    intc_sync_edge #(.W(NUM_SRC)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .rise  (rise),
        .level (sync_lvl)
    );

    generate
        if (NUM_SRC < 8) begin : g_wdata_unused
            logic unused_wdata;
            assign unused_wdata = ^cfg_wdata[7:NUM_SRC];
        end
    endgenerate

`ifdef INTC_LEVEL_TRIG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            level_en <= '0;
        else if (cfg_we && cfg_addr == INTC_LEVEL)
            level_en <= cfg_wdata[NUM_SRC-1:0];
    end
`else
    assign level_en = '0;
`endif

    assign eligible = pending & mask;
    assign win      = lowest(eligible);
    assign ack_take = (state == REQ) && int_ack;
    assign rfe_take = (state == SERVICE) && rfe;
    assign w1c      = (cfg_we && cfg_addr == INTC_PENDING) ? cfg_wdata[NUM_SRC-1:0] : '0;
    assign ack_clr  = ack_take ? (NUM_SRC'(1) << win) : '0;
    assign mask_nxt = (cfg_we && cfg_addr == INTC_MASK) ? cfg_wdata[NUM_SRC-1:0] : mask;

    // New edges (and high level sources) win over any clear landing in the same cycle.
    assign pending_nxt  = (pending & ~(w1c | ack_clr)) | rise | (sync_lvl & level_en);
    assign eligible_nxt = pending_nxt & mask_nxt;
    assign win_nxt      = lowest(eligible_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|eligible && |eligible_nxt) state_nxt = REQ;
            REQ:     if (int_ack)            state_nxt = SERVICE;
                     else if (!(|eligible_nxt)) state_nxt = IDLE;
            SERVICE: if (rfe)                state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            mask       <= '0;
            svc_id     <= '0;
            svc_valid  <= 1'b0;
            int_sig    <= 1'b0;
            int_vector <= VEC_BASE;
        end else begin
            pending <= pending_nxt;
            mask    <= mask_nxt;
            int_sig <= (state_nxt == REQ);
            if (state_nxt == REQ)
                int_vector <= intc_vector(win_nxt, VEC_BASE, VEC_STRIDE);
            if (ack_take) begin
                svc_id    <= win;
                svc_valid <= 1'b1;
            end else if (rfe_take) begin
                svc_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            INTC_PENDING: cfg_rdata[NUM_SRC-1:0] = pending;
            INTC_MASK:    cfg_rdata[NUM_SRC-1:0] = mask;
            INTC_CAUSE:   cfg_rdata = {svc_valid, 4'b0000, svc_id};
            default:      cfg_rdata[NUM_SRC-1:0] = level_en;
        endcase
    end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios plus randomized traffic against an event-level model.
module tb_int_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq;
    logic        int_sig;
    logic [31:0] int_vector;
    logic        int_ack;
    logic        rfe;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;

    int total = 0;
    int bad   = 0;

    int_controller #(
        .NUM_SRC    (4),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .int_sig    (int_sig),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .rfe        (rfe),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic pulse_rfe();
        rfe = 1'b1; tick(); rfe = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; irq = '0; int_ack = 1'b0; rfe = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        apply_reset();
        total++; if (int_sig !== 1'b0) begin bad++; $display("FAIL reset_int_sig: got %b want 0", int_sig); end
        total++; if (int_vector !== 32'h100) begin bad++; $display("FAIL reset_vector: got %h want 00000100", int_vector); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_reg%0d: got %h want 00", a, d); end
        end
`ifndef INTC_LEVEL_TRIG_EN
        cfg_write(2'd3, 8'hFF);
        read_reg(2'd3, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reserved_reg: got %h want 00", d); end
`endif
    endtask

    task automatic test_basic();
        logic [7:0] d;
        apply_reset();
        cfg_write(2'd1, 8'h03);
        irq[1] = 1'b1;
        tick();                 // edge k samples the rise
        irq[1] = 1'b0;
        ticks(2);               // k+2
        read_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL basic_pend_early: got %h want 00", d); end
        tick();                 // k+3
        read_reg(2'd0, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL basic_pend_k3: got %h want 02", d); end
        total++; if (int_sig !== 1'b0) begin bad++; $display("FAIL basic_sig_k3: got %b want 0", int_sig); end
        tick();
        total++; if (int_sig !== 1'b1) begin bad++; $display("FAIL basic_sig: got %b want 1", int_sig); end
        total++; if (int_vector !== 32'h110) begin bad++; $display("FAIL basic_vector: got %h want 00000110", int_vector); end
        pulse_ack();
        total++; if (int_sig !== 1'b0) begin bad++; $display("FAIL basic_sig_ack: got %b want 0", int_sig); end
        read_reg(2'd2, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL basic_cause: got %h want 81", d); end
        read_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL basic_pend_ack: got %h want 00", d); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        apply_reset();
        cfg_write(2'd1, 8'h0F);
        irq = 4'b1001;
        tick();
        irq = '0;
        ticks(4);
        total++; if (int_vector !== 32'h100 || int_sig !== 1'b1) begin bad++; $display("FAIL prio_first: got sig=%b vec=%h want 1/00000100", int_sig, int_vector); end
        pulse_ack();
        read_reg(2'd2, d);
        total++; if (d !== 8'h80) begin bad++; $display("FAIL prio_cause: got %h want 80", d); end
        ticks(2);
        total++; if (int_sig !== 1'b0) begin bad++; $display("FAIL prio_no_nest: got %b want 0", int_sig); end
        pulse_rfe();
        total++; if (int_sig !== 1'b0) begin bad++; $display("FAIL prio_rfe_gap: got %b want 0", int_sig); end
        tick();
        total++; if (int_sig !== 1'b1 || int_vector !== 32'h130) begin bad++; $display("FAIL prio_second: got sig=%b vec=%h want 1/00000130", int_sig, int_vector); end
    endtask

    task automatic test_mask_w1c();
        logic [7:0] d;
        apply_reset();
        irq[2] = 1'b1; tick(); irq[2] = 1'b0;
        ticks(5);
        read_reg(2'd0, d);
        total++; if (d !== 8'h04 || int_sig !== 1'b0) begin bad++; $display("FAIL masked: got pend=%h sig=%b want 04/0", d, int_sig); end
        cfg_write(2'd1, 8'h04);
        tick();
        total++; if (int_sig !== 1'b1 || int_vector !== 32'h120) begin bad++; $display("FAIL unmask: got sig=%b vec=%h want 1/00000120", int_sig, int_vector); end
        cfg_write(2'd0, 8'h04);
        read_reg(2'd0, d);
        total++; if (int_sig !== 1'b0 || d !== 8'h00) begin bad++; $display("FAIL w1c_cancel: got sig=%b pend=%h want 0/00", int_sig, d); end
        ticks(2);
        total++; if (int_sig !== 1'b0) begin bad++; $display("FAIL w1c_idle: got %b want 0", int_sig); end
    endtask

    task automatic test_service_accum();
        logic [7:0] d;
        apply_reset();
        cfg_write(2'd1, 8'h0F);
        irq[1] = 1'b1; tick(); irq[1] = 1'b0;
        ticks(4);
        pulse_ack();
        irq[0] = 1'b1; tick(); irq[0] = 1'b0;
        ticks(4);
        read_reg(2'd0, d);
        total++; if (int_sig !== 1'b0 || d !== 8'h01) begin bad++; $display("FAIL svc_accum: got sig=%b pend=%h want 0/01", int_sig, d); end
        pulse_rfe();
        tick();
        total++; if (int_sig !== 1'b1 || int_vector !== 32'h100) begin bad++; $display("FAIL svc_after_rfe: got sig=%b vec=%h want 1/00000100", int_sig, int_vector); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        apply_reset();
        cfg_write(2'd1, 8'h02);
        irq[1] = 1'b1; tick(); irq[1] = 1'b0;
        ticks(4);
        irq[1] = 1'b1;
        tick();                 // k
        irq[1] = 1'b0;
        ticks(2);               // k+2
        int_ack = 1'b1;
        tick();                 // k+3: ack and new set coincide
        int_ack = 1'b0;
        read_reg(2'd0, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL set_beats_ack: got %h want 02", d); end
        read_reg(2'd2, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL b2b_cause: got %h want 81", d); end
        rst_n = 1'b0;
        #1;
        read_reg(2'd2, d);
        total++; if (int_sig !== 1'b0 || int_vector !== 32'h100 || d !== 8'h00) begin bad++; $display("FAIL mid_reset: got sig=%b vec=%h cause=%h want 0/00000100/00", int_sig, int_vector, d); end
        read_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_reset_pend: got %h want 00", d); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef INTC_LEVEL_TRIG_EN
    task automatic test_level();
        logic [7:0] d;
        apply_reset();
        cfg_write(2'd3, 8'h01);
        irq[0] = 1'b1;
        ticks(4);
        cfg_write(2'd0, 8'h01);
        read_reg(2'd0, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL level_w1c_held: got %h want 01", d); end
        irq[0] = 1'b0;
        ticks(4);
        cfg_write(2'd0, 8'h01);
        read_reg(2'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL level_w1c_released: got %h want 00", d); end
    endtask
`endif

    // Event-level reference: a pending bit is raised three sampled edges after an irq rise,
    // or two after a level source is seen high; at most one interrupt is in service.
    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic test_random();
        logic [3:0]  hist [0:4];
        logic [3:0]  m_pend, m_mask, m_level, m_set, m_clr, m_elig, pend_n, mask_n, level_n, elig_n;
        logic        m_req, m_valid, req_n, valid_n;
        logic [2:0]  m_id, id_n;
        logic [31:0] m_vec;
        logic [7:0]  want;
        logic        r_ack, r_rfe, r_we;
        logic [1:0]  r_addr;
        logic [7:0]  r_wdata;
        int          b;
        apply_reset();
        for (int i = 0; i < 5; i++) hist[i] = '0;
        m_pend = '0; m_mask = '0; m_level = '0; m_req = 1'b0; m_valid = 1'b0; m_id = '0; m_vec = 32'h100;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = int'($urandom_range(0, 3));
                irq[b] = ~irq[b];
            end
            r_ack   = ($urandom_range(0, 3) == 0);
            r_rfe   = ($urandom_range(0, 4) == 0);
            r_we    = ($urandom_range(0, 7) == 0);
            r_addr  = 2'($urandom_range(0, 3));
            r_wdata = 8'($urandom);
            int_ack = r_ack; rfe = r_rfe; cfg_we = r_we; cfg_addr = r_addr; cfg_wdata = r_wdata;

            for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = irq;
            m_set  = (hist[3] & ~hist[4]) | (m_level & hist[2]);
            m_elig = m_pend & m_mask;
            m_clr  = (r_we && r_addr == 2'd0) ? r_wdata[3:0] : 4'h0;
            if (m_req && r_ack) m_clr = m_clr | (4'h1 << first_set(m_elig));
            pend_n  = (m_pend & ~m_clr) | m_set;
            mask_n  = (r_we && r_addr == 2'd1) ? r_wdata[3:0] : m_mask;
`ifdef INTC_LEVEL_TRIG_EN
            level_n = (r_we && r_addr == 2'd3) ? r_wdata[3:0] : m_level;
`else
            level_n = 4'h0;
`endif
            elig_n  = pend_n & mask_n;
            req_n = 1'b0; valid_n = m_valid; id_n = m_id;
            if (m_req && r_ack) begin
                valid_n = 1'b1; id_n = 3'(first_set(m_elig));
            end else if (m_req) begin
                req_n = (elig_n != 0);
            end else if (m_valid) begin
                if (r_rfe) valid_n = 1'b0;
            end else begin
                req_n = (m_elig != 0) && (elig_n != 0);
            end

            tick();
            m_pend = pend_n; m_mask = mask_n; m_level = level_n;
            m_req = req_n; m_valid = valid_n; m_id = id_n;
            if (req_n) m_vec = 32'h100 + 32'(first_set(elig_n)) * 32'h10;
            cfg_we = 1'b0;

            case (r_addr)
                2'd0:    want = {4'h0, m_pend};
                2'd1:    want = {4'h0, m_mask};
                2'd2:    want = {m_valid, 4'h0, m_id};
                default: want = {4'h0, m_level};
            endcase
            total++; if (int_sig !== m_req) begin bad++; $display("FAIL rand_sig c=%0d: got %b want %b", c, int_sig, m_req); end
            total++; if (int_vector !== m_vec) begin bad++; $display("FAIL rand_vec c=%0d: got %h want %h", c, int_vector, m_vec); end
            total++; if (cfg_rdata !== want) begin bad++; $display("FAIL rand_reg%0d c=%0d: got %h want %h", r_addr, c, cfg_rdata, want); end
        end
        int_ack = 1'b0; rfe = 1'b0; irq = '0;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; int_ack = 1'b0; rfe = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        test_reset();
        test_basic();
        test_priority();
        test_mask_w1c();
        test_service_accum();
        test_back_to_back();
`ifdef INTC_LEVEL_TRIG_EN
        test_level();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Prioritised interrupt controller between peripheral IRQ lines (UART rx-ready, timer, LEDs/GPIO) and the multicycle control unit.
- Synchronises and edge-detects the sources, latches pending bits, applies a software mask and raises a single request to the CPU.
- Supplies the vector address for the interrupt PC source and tracks one in-service interrupt until RFE.
- Software accesses pending, mask and cause through a small memory-mapped config port.

Parameters:
- NUM_SRC, 4: number of interrupt sources, 1..8.
- VEC_BASE, 32'h0000_0100: vector address of source 0.
- VEC_STRIDE, 32'h10: byte spacing between vectors.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- irq  in  NUM_SRC  raw peripheral interrupt lines, asynchronous, rising-edge sensitive.
- int_sig  out  1  request to the control unit, registered level.
- int_vector  out  32  handler address, VEC_BASE + id*VEC_STRIDE.
- int_ack  in  1  one-cycle pulse when the control unit enters INTERRUPT (the int_save_pc cycle).
- rfe  in  1  one-cycle pulse when RFE executes.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  register select.
- cfg_wdata  in  8  write data.
- cfg_rdata  out  8  read data, combinational from cfg_addr.

Behaviour:
- Reset (async, rst_n=0): synchronisers, pending, mask, and the in-service id/valid clear to 0. State is IDLE, int_sig=0, int_vector=VEC_BASE. Reset mid-service abandons the service silently.
- Input path: 2-flop synchroniser per bit, then a rising-edge detector. An irq rise sampled at clk edge k sets pending[i] at edge k+3.
- Set/clear priority: a set always wins over a simultaneous clear from int_ack or a W1C write.
- eligible = pending & mask. winner = lowest-index set bit of eligible (index 0 = highest priority).
- FSM IDLE:
  - eligible != 0 -> REQ; int_sig=1 and int_vector = vector(winner) from the next cycle.
- FSM REQ:
  - Re-arbitrate every cycle; int_vector follows the current winner.
  - int_ack=1 -> capture winner into in-service id, clear that pending bit, set in-service valid, go to SERVICE; int_sig=0 next cycle.
  - eligible becomes 0 (mask or W1C) before ack -> IDLE; int_sig=0 next cycle.
  - If ack and eligible-becomes-0 coincide, ack wins on the previous winner.
- FSM SERVICE:
  - No nesting; int_sig held 0; new edges only accumulate in pending.
  - rfe=1 -> clear in-service valid, go to IDLE. The next request may assert one cycle later (2 cycles after rfe).
- int_ack outside REQ and rfe outside SERVICE are ignored.
- Register map:
  - 0 PENDING: read; write 1 clears.
  - 1 MASK: read/write, reset 0.
  - 2 CAUSE: read only, {valid, 4'b0, id[2:0]}.
  - 3: reserved (see option).
- Bits at or above NUM_SRC read 0 and ignore writes. Config writes take effect at the clock edge; reads are combinational.

Optional Feature:
- Macro INTC_LEVEL_TRIG_EN.
- Defined:
  - Address 3 is the LEVEL register (rw, reset 0).
  - A source with LEVEL[i]=1 sets pending[i] every cycle its synchronised line is high, so W1C is ineffective while it stays high.
  - Edge sources are unchanged.
- Undefined: all sources are edge-triggered; address 3 reads 0 and ignores writes.

Decomposition:
- Shared package intc_pkg:
  - Register address constants INTC_PENDING=0, INTC_MASK=1, INTC_CAUSE=2, INTC_LEVEL=3.
  - FSM state encoding IDLE/REQ/SERVICE.
  - The function computing the vector from id.
- One sub-module: intc_sync_edge, the per-bit 2-flop synchroniser plus rising-edge detector, instantiated NUM_SRC wide.

Test Plan:
- Reset, mask=4'b0011, pulse irq[1] -> pending=4'b0010 at edge k+3; int_sig=1 next cycle; int_vector=32'h110; ack -> CAUSE=8'h81, pending=0, int_sig=0.
- irq[3] and irq[0] rise together, mask=4'hF -> int_vector=32'h100. After ack and rfe, int_sig reasserts 2 cycles after rfe with int_vector=32'h130.
- Mask=0, pulse irq[2] -> pending=4'b0100, int_sig stays 0. Write MASK=4'b0100 -> int_sig=1 next cycle. Write PENDING=4'b0100 before ack -> IDLE, int_sig=0.
- In SERVICE, pulse irq[0] -> int_sig stays 0, pending[0]=1. rfe -> int_sig=1 with int_vector=32'h100.
- Edge on irq[1] landing in the same cycle as the ack of id 1 -> pending[1] remains 1. Assert rst_n=0 mid-SERVICE -> all outputs at reset values immediately.
- (INTC_LEVEL_TRIG_EN) LEVEL=4'b0001, irq[0] held high -> W1C of pending[0] fails; release irq[0], then W1C -> pending=0.
